// File: rtl/obi_rr_arbiter_if.sv
// OBI bundle of N parallel channels: N=1 is a single OBI port, N>1 the packed per-master
// side of a mux (channel k occupies addr[32k+31:32k], be[4k+3:4k], and so on).
interface obi_rr_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*32-1:0] addr;
    logic [N-1:0]    we;
    logic [N*4-1:0]  be;
    logic [N*32-1:0] wdata;
    logic [N-1:0]    rvalid;
    logic [N*32-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_rr_arbiter.sv
// NUM_M-to-1 OBI arbiter with an in-order response-routing FIFO. Round-robin by default;
// define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module obi_rr_arbiter #(
    parameter int NUM_M     = 2,
    parameter int MAX_OUTST = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    obi_rr_arbiter_if.slave  mst,
    obi_rr_arbiter_if.master slv
);
    localparam int IDW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = $clog2(MAX_OUTST + 1);

    typedef logic [IDW-1:0] id_t;
    typedef logic [PW-1:0]  ptr_t;

    id_t           rr_ptr;
    id_t           rr_winner;
    id_t           winner;
    id_t           locked_id;
    id_t           cand_id;
    logic          lock;
    logic          found;
    int            cand;
    id_t           fifo_q [MAX_OUTST];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          any_req;
    logic          accept;
    logic          pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: combinational logic uses blocking '='; every flop below uses non-blocking '<='.
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        rr_winner = rr_ptr;
        found     = 1'b0;
        cand      = 0;
        cand_id   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_M) cand = cand - NUM_M;
            cand_id = id_t'(cand);
            if (!found && mst.req[cand_id]) begin
                rr_winner = cand_id;
                found     = 1'b1;
            end
        end
    end

    // A stalled request keeps its slot: the presented master stays selected until granted.
    assign winner    = lock ? locked_id : rr_winner;
    assign any_req   = (|mst.req) || lock;
    assign fifo_full = (count == CW'(MAX_OUTST));
    assign accept    = slv.req[0] && slv.gnt[0];
    assign pop       = slv.rvalid[0] && (count != '0);

    assign slv.req[0] = any_req && !fifo_full;
    assign slv.addr   = mst.addr[int'(winner)*32 +: 32];
    assign slv.we[0]  = mst.we[winner];
    assign slv.be     = mst.be[int'(winner)*4 +: 4];
    assign slv.wdata  = mst.wdata[int'(winner)*32 +: 32];

    assign mst.gnt    = accept ? (NUM_M'(1) << winner) : '0;
    assign mst.rvalid = pop ? (NUM_M'(1) << fifo_q[rd_ptr]) : '0;
    assign mst.rdata  = {NUM_M{slv.rdata}};

`ifdef OBI_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(winner) == NUM_M - 1) ? '0 : winner + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock      <= 1'b0;
            locked_id <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (accept) begin
                lock <= 1'b0;
            end else if (slv.req[0]) begin
                lock      <= 1'b1;
                locked_id <= winner;
            end
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (accept) fifo_q[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_obi_rr_arbiter;
    localparam int NUM_M     = 2;
    localparam int MAX_OUTST = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    obi_rr_arbiter_if #(.N(NUM_M)) mst ();
    obi_rr_arbiter_if #(.N(1))     slv ();

    obi_rr_arbiter #(.NUM_M(NUM_M), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .mst    (mst),
        .slv    (slv)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        mst.req    = '0;
        mst.addr   = {32'h1000_0004, 32'h1000_0000};
        mst.we     = '0;
        mst.be     = '1;
        mst.wdata  = '0;
        slv.gnt    = '0;
        slv.rvalid = '0;
        slv.rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_i);
        n_tests++;
        if (slv.req !== 1'b0 || mst.gnt !== 2'b00 || mst.rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: req=%b gnt=%b rvalid=%b, want 0/00/00", slv.req, mst.gnt, mst.rvalid);
        end
        next_cycle();
        mst.req = 2'b01;
        slv.gnt = 1'b1;
        next_cycle();
        next_cycle();
        n_tests++;
        if (dut.count !== 2) begin
            n_fail++;
            $display("FAIL reset_preload: count=%0d, want 2", dut.count);
        end
        rst_ni     = 1'b0;
        mst.req    = '0;
        slv.gnt    = 1'b0;
        slv.rvalid = 1'b1;
        #1;
        n_tests++;
        if (slv.req !== 1'b0 || mst.gnt !== 2'b00 || mst.rvalid !== 2'b00 || dut.count !== 0) begin
            n_fail++;
            $display("FAIL reset_midburst: req=%b gnt=%b rvalid=%b count=%0d, want 0/00/00/0",
                     slv.req, mst.gnt, mst.rvalid, dut.count);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        slv.rvalid = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (mst.rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_late_rvalid: m_rvalid=%b, want 00", mst.rvalid);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_rr_fairness();
        logic [1:0] eg, er;
        apply_reset();
        mst.req = 2'b11;
        slv.gnt = 1'b1;
        for (int c = 0; c < 8; c++) begin
            slv.rvalid = (c > 0);
`ifdef OBI_ARB_FIXED_PRIO_EN
            eg = 2'b01;
            er = (c > 0) ? 2'b01 : 2'b00;
`else
            eg = 2'(1 << (c % 2));
            er = (c > 0) ? 2'(1 << ((c - 1) % 2)) : 2'b00;
`endif
            @(negedge clk_i);
            n_tests++;
            if (mst.gnt !== eg || mst.rvalid !== er) begin
                n_fail++;
                $display("FAIL fairness cyc%0d: gnt=%b rvalid=%b, want %b/%b", c, mst.gnt, mst.rvalid, eg, er);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_stall_lock();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            mst.req = (c == 0) ? 2'b10 : 2'b11;
            slv.gnt = (c == 3);
            @(negedge clk_i);
            n_tests++;
            if (slv.addr !== 32'h1000_0004 || slv.req !== 1'b1 || mst.gnt !== ((c == 3) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL stall_lock cyc%0d: addr=%h req=%b gnt=%b, want 10000004/1/%b",
                         c, slv.addr, slv.req, mst.gnt, (c == 3) ? 2'b10 : 2'b00);
            end
            next_cycle();
        end
        @(negedge clk_i);
        n_tests++;
        if (mst.gnt !== 2'b01 || slv.addr !== 32'h1000_0000) begin
            n_fail++;
            $display("FAIL stall_after: gnt=%b addr=%h, want 01/10000000", mst.gnt, slv.addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full();
        logic [1:0] eg [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        logic       erq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        mst.req = 2'b01;
        slv.gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            slv.rvalid = (c == 3);
            @(negedge clk_i);
            n_tests++;
            if (slv.req !== erq[c] || mst.gnt !== eg[c] || mst.rvalid !== ((c == 3) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL full cyc%0d: req=%b gnt=%b rvalid=%b, want %b/%b/%b",
                         c, slv.req, mst.gnt, mst.rvalid, erq[c], eg[c], (c == 3) ? 2'b01 : 2'b00);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_routing();
        apply_reset();
        mst.req = 2'b10;
        mst.addr[63:32] = 32'h0000_0020;
        mst.we = 2'b00;
        slv.gnt = 1'b1;
        @(negedge clk_i);
        n_tests++;
        if (mst.gnt !== 2'b10 || slv.addr !== 32'h20 || slv.we !== 1'b0) begin
            n_fail++;
            $display("FAIL route_rd: gnt=%b addr=%h we=%b, want 10/00000020/0", mst.gnt, slv.addr, slv.we);
        end
        next_cycle();
        mst.req = 2'b01;
        mst.addr[31:0] = 32'h0000_0024;
        mst.we = 2'b01;
        mst.be = 8'h3C;
        mst.wdata[31:0] = 32'hCAFE_0001;
        @(negedge clk_i);
        n_tests++;
        if (mst.gnt !== 2'b01 || slv.addr !== 32'h24 || slv.we !== 1'b1 || slv.be !== 4'hC
            || slv.wdata !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL route_wr: gnt=%b addr=%h we=%b be=%h wdata=%h, want 01/00000024/1/c/cafe0001",
                     mst.gnt, slv.addr, slv.we, slv.be, slv.wdata);
        end
        next_cycle();
        mst.req = 2'b00;
        slv.gnt = 1'b0;
        slv.rvalid = 1'b1;
        slv.rdata = 32'hDEAD_BEEF;
        @(negedge clk_i);
        n_tests++;
        if (mst.rvalid !== 2'b10 || mst.rdata[63:32] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL route_resp1: rvalid=%b rdata1=%h, want 10/deadbeef", mst.rvalid, mst.rdata[63:32]);
        end
        next_cycle();
        slv.rdata = 32'h0;
        @(negedge clk_i);
        n_tests++;
        if (mst.rvalid !== 2'b01 || mst.rdata[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL route_resp2: rvalid=%b rdata0=%h, want 01/00000000", mst.rvalid, mst.rdata[31:0]);
        end
        next_cycle();
        @(negedge clk_i);
        n_tests++;
        if (mst.rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL route_empty_rvalid: rvalid=%b, want 00", mst.rvalid);
        end
        next_cycle();
        idle_inputs();
    endtask

    // Reference: outstanding IDs in a queue, next-priority index, and a stall lock.
    task automatic test_random();
        int               q[$];
        int               prio = 0;
        bit               mlock = 0;
        int               mlock_id = 0;
        int               win;
        bit               e_req;
        logic [NUM_M-1:0] e_gnt, e_rv;
        logic [NUM_M-1:0] granted = '1;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (!mst.req[k] || granted[k]) begin
                    mst.req[k] = ($urandom_range(0, 9) < 6);
                    mst.addr[k*32 +: 32]  = $urandom;
                    mst.we[k]             = $urandom_range(0, 1) == 1;
                    mst.be[k*4 +: 4]      = 4'($urandom);
                    mst.wdata[k*32 +: 32] = $urandom;
                end
            end
            slv.gnt    = ($urandom_range(0, 3) != 0);
            slv.rvalid = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            slv.rdata  = $urandom;

            win = -1;
            if (mlock) win = mlock_id;
            else for (int i = 0; i < NUM_M; i++) begin
                int k = (prio + i) % NUM_M;
                if (win < 0 && mst.req[k]) win = k;
            end
            e_req = (win >= 0) && (q.size() < MAX_OUTST);
            e_gnt = (e_req && slv.gnt[0]) ? NUM_M'(1 << win) : '0;
            e_rv  = (slv.rvalid[0] && q.size() > 0) ? NUM_M'(1 << q[0]) : '0;

            @(negedge clk_i);
            n_tests++;
            if (slv.req !== e_req || mst.gnt !== e_gnt || mst.rvalid !== e_rv) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc%0d: req=%b gnt=%b rvalid=%b, want %b/%b/%b",
                         c, slv.req, mst.gnt, mst.rvalid, e_req, e_gnt, e_rv);
            end
            if (e_req) begin
                n_tests++;
                if (slv.addr !== mst.addr[win*32 +: 32] || slv.we !== mst.we[win]
                    || slv.be !== mst.be[win*4 +: 4] || slv.wdata !== mst.wdata[win*32 +: 32]) begin
                    n_fail++;
                    $display("FAIL rand_mux cyc%0d: addr=%h we=%b be=%h wdata=%h, want master %0d",
                             c, slv.addr, slv.we, slv.be, slv.wdata, win);
                end
            end
            n_tests++;
            if (mst.rdata !== {NUM_M{slv.rdata}}) begin
                n_fail++;
                $display("FAIL rand_rdata cyc%0d: rdata=%h, want %h broadcast", c, mst.rdata, slv.rdata);
            end

            if (slv.rvalid[0] && q.size() > 0) void'(q.pop_front());
            if (e_req && slv.gnt[0]) begin
                q.push_back(win);
                mlock = 0;
`ifdef OBI_ARB_FIXED_PRIO_EN
                prio = 0;
`else
                prio = (win + 1) % NUM_M;
`endif
            end else if (e_req) begin
                mlock    = 1;
                mlock_id = win;
            end
            granted = e_gnt;
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_fairness();
        test_stall_lock();
        test_full();
        test_routing();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
